// File: rtl/cms_ctrl_pkg.sv
// rtl/cms_ctrl_pkg.sv - shared types and constants for the control-port write sequencer
package cms_ctrl_pkg;

  localparam int CTRL_ADDR_WIDTH_DEF = 8;
  localparam int CTRL_DATA_WIDTH_DEF = 64;

  typedef struct packed {
    logic [CTRL_ADDR_WIDTH_DEF-1:0] addr;
    logic [CTRL_DATA_WIDTH_DEF-1:0] wdata;
  } ctrl_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cms_ctrl_fifo.sv
// rtl/cms_ctrl_fifo.sv - synchronous command FIFO with wrap-bit pointers
module cms_ctrl_fifo
  import cms_ctrl_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type cmd_t = ctrl_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Full is judged on the registered pointers only, so a same-cycle pop never frees a slot early.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// rtl/cms_ctrl_sequencer.sv - two-requester arbiter, command FIFO and write-strobe sequencer
module cms_ctrl_sequencer
  import cms_ctrl_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = CTRL_ADDR_WIDTH_DEF,
  parameter int CTRL_DATA_WIDTH = CTRL_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH      = 4,
  parameter int WE_HIGH_CYCLES  = 1,
  parameter int WE_GAP_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] req0_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] req0_wdata,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] req1_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] req1_wdata,
  output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       busy,
  output logic [15:0]                issued_count
);

  typedef struct packed {
    logic [CTRL_ADDR_WIDTH-1:0] addr;
    logic [CTRL_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam int PH_MAX = max_int(WE_HIGH_CYCLES, WE_GAP_CYCLES);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(WE_HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(WE_GAP_CYCLES - 1);

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  cmd_t       push_cmd;
  cmd_t       head_cmd;

  // last_grant: 1 means req1 won the previous handshake, so req0 is favoured next.
  logic       last_grant;
  logic       pick1;

  seq_state_t state;
  seq_state_t state_n;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_n;
  logic       load;
  logic       count_inc;

  always_comb begin
    pick1 = !last_grant;
    if (req0_valid && !req1_valid)      pick1 = 1'b0;
    else if (req1_valid && !req0_valid) pick1 = 1'b1;
  end

  assign req0_ready = !fifo_full && !pick1;
  assign req1_ready = !fifo_full && pick1;
  assign fifo_push  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign push_cmd   = pick1 ? cmd_t'{addr: req1_addr, wdata: req1_wdata}
                            : cmd_t'{addr: req0_addr, wdata: req0_wdata};

  always_ff @(posedge clk) begin
    if (rst)            last_grant <= 1'b1;
    else if (fifo_push) last_grant <= pick1;
  end

  cms_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      ctrl_addr    <= '0;
      ctrl_wdata   <= '0;
      issued_count <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      if (load) begin
        ctrl_addr  <= head_cmd.addr;
        ctrl_wdata <= head_cmd.wdata;
      end
      if (count_inc) issued_count <= issued_count + 16'd1;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    load      = 1'b0;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n   = PULSE;
        phase_n   = '0;
        count_inc = 1'b1;
      end
      PULSE: begin
        if (phase == HIGH_LAST) begin
          state_n = GAP;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      GAP: begin
        // Chaining straight into SETUP keeps back-to-back pulses at a fixed pitch.
        if (phase == GAP_LAST) begin
          phase_n = '0;
          if (!fifo_empty) begin
            load    = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ctrl_write_enable = (state == PULSE);
    busy              = (state != IDLE) || !fifo_empty;
  end

endmodule
